// File: rtl/ram_loader.sv
// Download-to-RAM loader: writes an ioctl byte stream into a RAM window and arbitrates CPU access.
// Optional feature: define RAM_LOADER_CLEAR_EN to zero the whole RAM after every reset.
module ram_loader #(
    parameter int unsigned addr_width_g = 11,
    parameter int unsigned data_width_g = 8,
    parameter logic [24:0] base_addr_g  = 25'h0,
    parameter logic [7:0]  index_g      = 8'h00
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ioctl_download,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic                    ioctl_wait,
    input  logic                    cpu_en,
    input  logic                    cpu_we,
    input  logic [addr_width_g-1:0] cpu_addr,
    input  logic [data_width_g-1:0] cpu_din,
    output logic                    cpu_busy,
    output logic                    ram_clken,
    output logic                    ram_wren,
    output logic [addr_width_g-1:0] ram_address,
    output logic [data_width_g-1:0] ram_data,
    output logic                    load_done,
    output logic [addr_width_g:0]   load_count
);

    localparam logic [25:0] WinSize = 26'(1) << addr_width_g;
    localparam logic [addr_width_g:0] CountMax = {1'b1, {addr_width_g{1'b0}}};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1
`ifdef RAM_LOADER_CLEAR_EN
        ,
        StClear = 2'd2
`endif
    } state_e;

`ifdef RAM_LOADER_CLEAR_EN
    localparam state_e StReset   = StClear;
    localparam logic   ResetBusy = 1'b1;
`else
    localparam state_e StReset   = StIdle;
    localparam logic   ResetBusy = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic [addr_width_g-1:0] pend_addr_q, pend_addr_d;
    logic [data_width_g-1:0] pend_data_q, pend_data_d;
    logic [addr_width_g:0]   load_count_q, load_count_d;
    logic                    load_done_q, load_done_d;
`ifdef RAM_LOADER_CLEAR_EN
    logic [addr_width_g-1:0] clr_cnt_q, clr_cnt_d;
`endif

    logic        selected;
    logic        in_window;
    logic [25:0] offset;

    // 26-bit offset: an address below the base wraps to a huge value and fails the bound.
    always_comb begin
        selected  = ioctl_download && (ioctl_index == index_g);
        offset    = {1'b0, ioctl_addr} - {1'b0, base_addr_g};
        in_window = selected && (offset < WinSize);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            load_count_q <= '0;
            load_done_q  <= 1'b0;
`ifdef RAM_LOADER_CLEAR_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            load_count_q <= load_count_d;
            load_done_q  <= load_done_d;
`ifdef RAM_LOADER_CLEAR_EN
            clr_cnt_q    <= clr_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = 1'b0;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        load_count_d = load_count_q;
        load_done_d  = load_done_q;
`ifdef RAM_LOADER_CLEAR_EN
        clr_cnt_d    = clr_cnt_q;
`endif
        case (state_q)
`ifdef RAM_LOADER_CLEAR_EN
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = StIdle;
                end
            end
`endif
            StIdle: begin
                if (selected) begin
                    state_d      = StLoad;
                    load_count_d = '0;
                    pend_d       = ioctl_wr && in_window;
                end
            end
            StLoad: begin
                // The byte pending now is written this cycle, even on the exit cycle.
                if (pend_q && (load_count_q != CountMax)) begin
                    load_count_d = load_count_q + 1'b1;
                end
                if (!selected) begin
                    state_d     = StIdle;
                    load_done_d = 1'b1;
                end
                pend_d = ioctl_wr && in_window;
            end
            default: begin
                state_d = StReset;
            end
        endcase
        if (pend_d) begin
            pend_addr_d = offset[addr_width_g-1:0];
            pend_data_d = data_width_g'(ioctl_dout);
        end
    end

    always_comb begin
        ioctl_wait  = 1'b0;
        cpu_busy    = 1'b0;
        ram_clken   = 1'b0;
        ram_wren    = 1'b0;
        ram_address = cpu_addr;
        ram_data    = cpu_din;
        if (reset) begin
            ioctl_wait = ResetBusy;
            cpu_busy   = ResetBusy;
        end else begin
            case (state_q)
`ifdef RAM_LOADER_CLEAR_EN
                StClear: begin
                    ioctl_wait  = 1'b1;
                    cpu_busy    = 1'b1;
                    ram_clken   = 1'b1;
                    ram_wren    = 1'b1;
                    ram_address = clr_cnt_q;
                    ram_data    = '0;
                end
`endif
                StIdle: begin
                    ram_clken = cpu_en;
                    ram_wren  = cpu_en & cpu_we;
                end
                StLoad: begin
                    cpu_busy    = 1'b1;
                    ram_clken   = pend_q;
                    ram_wren    = pend_q;
                    ram_address = pend_addr_q;
                    ram_data    = pend_data_q;
                end
                default: begin
                    cpu_busy = 1'b1;
                end
            endcase
        end
    end

    assign load_done  = load_done_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader (addr_width_g=4, base 0x100, index 0): directed and random steps
// checked against a cycle-level behavioural model of the loader rules.
module tb_ram_loader;

    localparam int Aw    = 4;
    localparam int Win   = 16;
    localparam int Base  = 'h100;
`ifdef RAM_LOADER_CLEAR_EN
    localparam bit ClrEn = 1'b1;
`else
    localparam bit ClrEn = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          cpu_en;
    logic          cpu_we;
    logic [Aw-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_busy;
    logic          ram_clken;
    logic          ram_wren;
    logic [Aw-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          load_done;
    logic [Aw:0]   load_count;

    ram_loader #(
        .addr_width_g(Aw),
        .data_width_g(8),
        .base_addr_g (25'h100),
        .index_g     (8'h00)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .cpu_en        (cpu_en),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_din       (cpu_din),
        .cpu_busy      (cpu_busy),
        .ram_clken     (ram_clken),
        .ram_wren      (ram_wren),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .load_done     (load_done),
        .load_count    (load_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int step     = 0;

    // Behavioural model state
    bit       m_load, m_pend, m_done;
    int       m_paddr, m_pdata, m_count;
    bit [7:0] exp_mem   [Win];
    bit       exp_valid [Win];
    logic [7:0] shadow  [Win];

    // RAM mirror: what the DUT actually wrote, sampled mid-cycle
    always @(negedge clock) begin
        if (!reset && ram_clken && ram_wren) shadow[ram_address] <= ram_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s step=%0d: observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    function automatic bit model_in_win(input bit dl, input bit [7:0] idx, input int addr);
        return dl && (idx == 8'h00) && (addr >= Base) && (addr < Base + Win);
    endfunction

    // One clock cycle: apply inputs, check outputs against the model, advance the model.
    task automatic drive(input bit dl, input bit [7:0] idx, input bit wr, input int addr,
                         input int dout, input bit ce, input bit we, input int ca, input int cd);
        bit nxt_pend;
        bit sel;
        step++;
        ioctl_download = dl;
        ioctl_index    = idx;
        ioctl_wr       = wr;
        ioctl_addr     = 25'(addr);
        ioctl_dout     = 8'(dout);
        cpu_en         = ce;
        cpu_we         = we;
        cpu_addr       = Aw'(ca);
        cpu_din        = 8'(cd);
        #1;
        check("ioctl_wait", ioctl_wait, 0);
        check("load_count", load_count, m_count);
        check("load_done", load_done, m_done);
        if (m_load) begin
            check("load_busy", cpu_busy, 1);
            check("load_wren", ram_wren, m_pend);
            check("load_clken", ram_clken, m_pend);
            if (m_pend) begin
                check("load_addr", ram_address, m_paddr);
                check("load_data", ram_data, m_pdata);
            end
        end else begin
            check("idle_busy", cpu_busy, 0);
            check("idle_clken", ram_clken, ce);
            check("idle_wren", ram_wren, ce && we);
            check("idle_addr", ram_address, ca);
            check("idle_data", ram_data, cd);
        end
        sel      = dl && (idx == 8'h00);
        nxt_pend = m_load && wr && model_in_win(dl, idx, addr);
        if (!m_load && ce && we) begin
            exp_mem[ca]   = 8'(cd);
            exp_valid[ca] = 1'b1;
        end
        if (m_load && m_pend) begin
            exp_mem[m_paddr]   = 8'(m_pdata);
            exp_valid[m_paddr] = 1'b1;
            m_count = (m_count < Win) ? m_count + 1 : Win;
        end
        if (!m_load && sel) begin
            m_load  = 1'b1;
            m_count = 0;
        end else if (m_load && !sel) begin
            m_load = 1'b0;
            m_done = 1'b1;
        end
        m_pend  = nxt_pend;
        m_paddr = (addr - Base) % Win;
        m_pdata = dout;
        @(posedge clock);
        #1;
    endtask

    task automatic dl_byte(input int addr, input int dout);
        drive(1'b1, 8'h00, 1'b1, addr, dout, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic dl_hold(input bit dl, input bit [7:0] idx);
        drive(dl, idx, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        step++;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        cpu_en         = 1'b1;
        cpu_we         = 1'b1;
        cpu_addr       = 4'd2;
        cpu_din        = 8'h33;
        #1;
        check("rst_wren", ram_wren, 0);
        check("rst_clken", ram_clken, 0);
        check("rst_wait", ioctl_wait, ClrEn);
        check("rst_busy", cpu_busy, ClrEn);
        @(posedge clock);
        #1;
        check("rst_count", load_count, 0);
        check("rst_done", load_done, 0);
        check("rst_wren2", ram_wren, 0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        cpu_en = 1'b0;
        cpu_we = 1'b0;
        m_load = 1'b0;
        m_pend = 1'b0;
        m_done = 1'b0;
        m_count = 0;
`ifdef RAM_LOADER_CLEAR_EN
        for (int i = 0; i < Win; i++) begin
            step++;
            ioctl_download = 1'b1;
            ioctl_wr       = 1'b1;
            ioctl_addr     = 25'(Base + 3);
            cpu_en         = 1'b1;
            cpu_we         = 1'b1;
            cpu_addr       = Aw'(Win - 1 - i);
            cpu_din        = 8'hFF;
            #1;
            check("clr_wren", ram_wren, 1);
            check("clr_addr", ram_address, i);
            check("clr_data", ram_data, 0);
            check("clr_wait", ioctl_wait, 1);
            check("clr_busy", cpu_busy, 1);
            check("clr_count", load_count, 0);
            @(posedge clock);
            #1;
        end
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        cpu_en         = 1'b0;
        cpu_we         = 1'b0;
        for (int i = 0; i < Win; i++) begin
            exp_mem[i]   = 8'h00;
            exp_valid[i] = 1'b1;
        end
`endif
    endtask

    initial begin
        bit       dl;
        bit [7:0] idx;
        bit       wr;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'h00;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        cpu_en = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_din = '0;
        for (int i = 0; i < Win; i++) exp_valid[i] = 1'b0;
        @(posedge clock);
        #1;
        do_reset();

        // CPU owns the RAM in IDLE
        drive(1'b0, 8'h00, 1'b0, 0, 0, 1'b1, 1'b1, 7, 'h5A);
        drive(1'b0, 8'h00, 1'b0, 0, 0, 1'b1, 1'b0, 7, 'h00);
        drive(1'b1, 8'h01, 1'b1, Base, 'h11, 1'b1, 1'b1, 3, 'h11);

        // Session 1: two consecutive bytes, boundary drops, CPU ignored
        drive(1'b1, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 8'h00, 1'b1, 'h100, 'hA5, 1'b1, 1'b1, 9, 'h66);
        dl_byte('h101, 'h3C);
        dl_byte('h0FF, 'h77);
        dl_byte(Base + Win, 'h88);
        dl_hold(1'b1, 8'h00);
        dl_byte('h10F, 'h99);
        dl_hold(1'b0, 8'h00);
        dl_hold(1'b0, 8'h00);

        // Session 2: back-to-back burst past saturation, then a byte coinciding with the drop
        dl_hold(1'b1, 8'h00);
        for (int i = 0; i < Win + 2; i++) dl_byte(Base + (i % Win), 'hC0 + i);
        dl_hold(1'b1, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 'h105, 'hEE, 1'b0, 1'b0, 0, 0);
        dl_hold(1'b0, 8'h00);

        // Session 3: ends by index change; pending byte still lands
        dl_hold(1'b1, 8'h00);
        dl_byte('h102, 'h42);
        dl_hold(1'b1, 8'h01);
        drive(1'b1, 8'h01, 1'b1, 'h103, 'h24, 1'b1, 1'b1, 4, 'h24);
        dl_hold(1'b0, 8'h00);

        // Random traffic, addresses straddling both window edges
        for (int n = 0; n < 400; n++) begin
            if (m_load) begin
                dl  = ($urandom_range(0, 19) != 0);
                idx = ($urandom_range(0, 29) == 0) ? 8'h02 : 8'h00;
                wr  = ($urandom_range(0, 9) < 6);
            end else begin
                dl  = ($urandom_range(0, 3) == 0);
                idx = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
                wr  = 1'b0;
            end
            drive(dl, idx, wr, 'hF8 + $urandom_range(0, 31), $urandom_range(0, 255),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, Win - 1), $urandom_range(0, 255));
        end
        dl_hold(1'b0, 8'h00);

        // Reset in the middle of a session with a byte pending
        dl_hold(1'b1, 8'h00);
        for (int i = 0; i < 5; i++) dl_byte(Base + 8 + i, 'h50 + i);
        do_reset();
        dl_hold(1'b0, 8'h00);
        dl_hold(1'b1, 8'h00);
        dl_byte('h10E, 'h5E);
        dl_hold(1'b0, 8'h00);
        dl_hold(1'b0, 8'h00);

        for (int i = 0; i < Win; i++) begin
            if (exp_valid[i]) check($sformatf("mem[%0d]", i), shadow[i], exp_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter addr_width_g, default 11: RAM address width; window size is 2^addr_width_g bytes.
REQ-002 Parameter data_width_g, default 8: RAM data width; only 8 is supported.
REQ-003 Parameter base_addr_g, default 25'h0: download byte address that maps to RAM address 0.
REQ-004 Parameter index_g, default 8'h00: ioctl_index value that selects this loader.
REQ-005 Ports, in order: name, direction, width, meaning.
  - clock in 1: single clock for the whole block.
  - reset in 1: synchronous, active-high reset.
  - ioctl_download in 1: download session active.
  - ioctl_index in 8: download target index.
  - ioctl_wr in 1: one-cycle byte strobe.
  - ioctl_addr in 25: byte address of the download.
  - ioctl_dout in 8: download byte.
  - ioctl_wait out 1: stall request to the download source.
  - cpu_en in 1: CPU access enable.
  - cpu_we in 1: CPU write.
  - cpu_addr in addr_width_g: CPU address.
  - cpu_din in data_width_g: CPU write data.
  - cpu_busy out 1: CPU access ignored this cycle.
  - ram_clken out 1: RAM clock enable.
  - ram_wren out 1: RAM write enable.
  - ram_address out addr_width_g: RAM address.
  - ram_data out data_width_g: RAM write data.
  - load_done out 1: at least one complete session has ended since reset.
  - load_count out addr_width_g+1: number of bytes written during the last or current session.

Function
REQ-006 The block SHALL implement three states: CLEAR, IDLE and LOAD.
REQ-007 A byte SHALL be "in window" when all of the following hold:
  - ioctl_download=1;
  - ioctl_index=index_g;
  - base_addr_g <= ioctl_addr < base_addr_g + 2^addr_width_g.
  The comparison SHALL use a 26-bit subtraction so there is no wrap.
REQ-008 CLEAR SHALL write 0 to RAM addresses 0 through 2^addr_width_g-1 in ascending order, one address per cycle. It SHALL then go to IDLE.
REQ-009 In CLEAR, the block SHALL hold ioctl_wait=1 and cpu_busy=1 and ignore every ioctl and CPU strobe.
REQ-010 IDLE to LOAD: the transition SHALL occur on the first cycle in which ioctl_download=1 and ioctl_index=index_g. load_count SHALL be zeroed on that same cycle.
REQ-011 In IDLE, RAM outputs SHALL follow the CPU combinationally:
  - ram_clken = cpu_en;
  - ram_wren = cpu_en & cpu_we;
  - ram_address = cpu_addr;
  - ram_data = cpu_din;
  - cpu_busy = 0.
REQ-012 LOAD write path:
  - An in-window ioctl_wr SHALL be registered.
  - The next cycle SHALL drive ram_clken=1, ram_wren=1, ram_address=ioctl_addr-base_addr_g (low addr_width_g bits) and ram_data=ioctl_dout.
  - Write latency SHALL be exactly 1 cycle from the ioctl_wr cycle.
REQ-013 Out-of-window ioctl_wr SHALL be dropped without a RAM write.
REQ-014 In LOAD:
  - cpu_busy=1 and CPU strobes SHALL be ignored;
  - ram_clken=0 on cycles with no pending byte;
  - ioctl_wait=0.
REQ-015 Back-to-back ioctl_wr on consecutive cycles SHALL each produce one RAM write on consecutive cycles, with none lost.
REQ-016 load_count SHALL increment by 1 per RAM write in LOAD. It SHALL saturate at 2^addr_width_g.
REQ-017 LOAD to IDLE: the transition SHALL occur on the cycle after ioctl_download falls or ioctl_index changes away from index_g.
  - A byte pending at that edge SHALL still be written first.
  - load_done SHALL be set to 1 on entry to IDLE and SHALL remain 1.
REQ-018 If ioctl_wr and ioctl_download fall in the same cycle, that byte SHALL NOT be written.

Reset
REQ-019 Reset held high SHALL give, on the next edge:
  - state=CLEAR (or IDLE when clear is compiled out);
  - clear counter=0;
  - load_count=0;
  - load_done=0;
  - pending byte discarded;
  - ram_wren=0;
  - ram_clken=0.
REQ-020 Reset asserted mid-CLEAR or mid-LOAD SHALL abort the operation and restart from the reset state. No partial write SHALL occur in the reset cycle.
REQ-021 ioctl_wait and cpu_busy SHALL be 1 during reset when clear is compiled in, and 0 otherwise.

Configuration
REQ-022 Macro RAM_LOADER_CLEAR_EN controls the CLEAR state.
  - Defined: the CLEAR state exists and runs after every reset.
  - Undefined: the CLEAR state and its counter are omitted, reset goes directly to IDLE, and RAM contents after reset are undefined.

Verification
REQ-023 Reset release with RAM_LOADER_CLEAR_EN, addr_width_g=4 -> 16 consecutive writes of 0 to addresses 0..15, ioctl_wait=1 throughout, IDLE on cycle 17.
REQ-024 base_addr_g=25'h100, index 0; ioctl_wr at 0x100=0xA5 and 0x101=0x3C on consecutive cycles -> RAM writes of address 0 = 0xA5 and address 1 = 0x3C on the following two cycles; load_count=2.
REQ-025 ioctl_wr at 0x0FF and at 0x100+2^addr_width_g -> no RAM write; load_count unchanged.
REQ-026 CPU cpu_en=1, cpu_we=1 during LOAD -> cpu_busy=1 and no RAM write; in IDLE -> ram_wren=1 with cpu_addr and cpu_din on the same cycle.
REQ-027 ioctl_download falls one cycle after the last ioctl_wr -> the byte is written, load_done=1 the next cycle, and the state is IDLE.
REQ-028 Reset pulsed mid-LOAD after 5 bytes -> load_count=0, load_done=0, CLEAR restarts from address 0.
